masked_share_scheduler: RTL and testbench

MASKED_SHARE_SCHEDULER -- requirements
Module: masked_share_scheduler

---
 rtl/masked_share_scheduler.sv | 88 ++++++++
 tb/tb_masked_share_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/masked_share_scheduler.sv
// masked_share_scheduler: round-robin two-requester scheduler splitting a secret into XOR shares with fresh RNG words
module masked_share_scheduler #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] secret0,
    input  logic [WIDTH-1:0] secret1,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [WIDTH-1:0] rnd_data,
    output logic [WIDTH-1:0] share0,
    output logic [WIDTH-1:0] share1,
    output logic             share_src,
    output logic             share_valid,
    input  logic             share_ready,
    output logic             rnd_timeout,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, WAIT_RND, OUT} state_t;
    state_t           r_state, w_next;
    logic             r_prio, r_gnt, r_src, r_valid, r_timeout;
    logic [WIDTH-1:0] r_secret, r_share0, r_share1;
    logic [7:0]       r_wait;
    logic             w_grant, w_gidx, w_take, w_expire;
    assign w_gidx   = (&req_valid) ? r_prio : req_valid[1];
    assign w_grant  = (r_state == IDLE) && (|req_valid);
    assign w_take   = (r_state == WAIT_RND) && rnd_valid;
    assign w_expire = (r_state == WAIT_RND) && !rnd_valid && (r_wait == 8'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE)     ? (w_grant ? WAIT_RND : IDLE) :
                 (r_state == WAIT_RND) ? (rnd_valid ? OUT : (w_expire ? IDLE : WAIT_RND)) :
                                         (share_ready ? IDLE : OUT);
    end
    always_comb begin
        req_ready = (!rst && w_grant) ? (w_gidx ? 2'b10 : 2'b01) : 2'b00;
        rnd_ready = !rst && (r_state == WAIT_RND);
        busy      = !rst && (r_state != IDLE);
    end
    // The secret register is wiped as soon as it is either masked or abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_gnt     <= 1'b0;
            r_src     <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_secret  <= '0;
            r_share0  <= '0;
            r_share1  <= '0;
            r_wait    <= '0;
        end else begin
            r_timeout <= w_expire;
            if (w_grant) begin
                r_secret <= w_gidx ? secret1 : secret0;
                r_gnt    <= w_gidx;
                r_prio   <= ~w_gidx;
                r_wait   <= '0;
            end
            if (r_state == WAIT_RND && !rnd_valid) r_wait <= r_wait + 8'd1;
            if (w_take) begin
                r_share0 <= r_secret ^ rnd_data;
                r_share1 <= rnd_data;
                r_src    <= r_gnt;
                r_valid  <= 1'b1;
                r_secret <= '0;
            end
            if (w_expire) r_secret <= '0;
            if (r_state == OUT && share_ready) begin
                r_valid  <= 1'b0;
                r_share0 <= '0;
                r_share1 <= '0;
            end
        end
    end
    assign share0      = r_share0;
    assign share1      = r_share1;
    assign share_src   = r_src;
    assign share_valid = r_valid;
    assign rnd_timeout = r_timeout;
endmodule

// File: tb/tb_masked_share_scheduler.sv
// tb_masked_share_scheduler: vector table, corner sequences and randomized run against a transaction-level model
module tb_masked_share_scheduler;
    localparam int TO = 16;
    logic       clk, rst, rnd_valid, rnd_ready, share_src, share_valid, share_ready, rnd_timeout, busy;
    logic [1:0] req_valid, req_ready;
    logic [7:0] secret0, secret1, rnd_data, share0, share1;

    masked_share_scheduler #(.WIDTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .secret0(secret0), .secret1(secret1), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .rnd_data(rnd_data), .share0(share0), .share1(share1), .share_src(share_src),
        .share_valid(share_valid), .share_ready(share_ready), .rnd_timeout(rnd_timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    bit m_pend, m_sv, m_turn, m_gnt, m_osrc, m_to;
    logic [7:0] m_sec, m_s0, m_s1;
    int m_wait;
    logic [1:0] s_rq;
    logic s_rr, s_busy, s_sv, s_src, s_to;
    logic [7:0] s_sh0, s_sh1;

    typedef struct {
        logic [1:0] rv; logic rvld; logic [7:0] rnd; logic sr;
        logic [1:0] e_rq; logic e_rr, e_busy, e_sv; logic [7:0] e_sh0, e_sh1; logic e_src;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare outputs with the model mid-cycle, then advance the model over the edge.
    task automatic cycle();
        logic [1:0] e_rq;
        bit w, idle;
        @(negedge clk);
        idle = !m_pend && !m_sv;
        w    = (req_valid == 2'b11) ? m_turn : req_valid[1];
        e_rq = (!rst && idle && |req_valid) ? (w ? 2'b10 : 2'b01) : 2'b00;
        s_rq = req_ready; s_rr = rnd_ready; s_busy = busy; s_sv = share_valid;
        s_sh0 = share0; s_sh1 = share1; s_src = share_src; s_to = rnd_timeout;
        chk("req_ready", 32'(req_ready), 32'(e_rq));
        chk("rnd_ready", 32'(rnd_ready), 32'(!rst && m_pend));
        chk("busy", 32'(busy), 32'(!rst && !idle));
        chk("share_valid", 32'(share_valid), 32'(m_sv));
        chk("share0", 32'(share0), 32'(m_s0));
        chk("share1", 32'(share1), 32'(m_s1));
        chk("share_src", 32'(share_src), 32'(m_osrc));
        chk("rnd_timeout", 32'(rnd_timeout), 32'(m_to));
        m_to = 1'b0;
        if (rst) begin
            m_pend = 0; m_sv = 0; m_turn = 0; m_gnt = 0; m_osrc = 0;
            m_sec = 0; m_s0 = 0; m_s1 = 0; m_wait = 0;
        end else if (m_pend) begin
            if (rnd_valid) begin
                m_s0 = m_sec ^ rnd_data; m_s1 = rnd_data; m_osrc = m_gnt; m_sv = 1; m_pend = 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin m_pend = 0; m_to = 1; end
            end
        end else if (m_sv) begin
            if (share_ready) begin m_sv = 0; m_s0 = 0; m_s1 = 0; end
        end else if (|req_valid) begin
            m_pend = 1; m_sec = w ? secret1 : secret0; m_gnt = w; m_turn = !w; m_wait = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic [1:0] rv, logic rvld, logic [7:0] rnd, logic sr);
        req_valid = rv; rnd_valid = rvld; rnd_data = rnd; share_ready = sr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(2'b00, 1'b0, 8'h00, 1'b0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int rr_cnt, to_cnt, sv_cnt, to_busy, good, mode;
        int hist[256];
        tbl[0]  = '{2'b01, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{2'b00, 1'b1, 8'h3C, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h99, 8'h3C, 1'b0};
        tbl[3]  = '{2'b11, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h99, 8'h3C, 1'b0};
        tbl[4]  = '{2'b11, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{2'b00, 1'b1, 8'h0F, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{2'b00, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h5A, 8'h0F, 1'b1};
        tbl[7]  = '{2'b11, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[8]  = '{2'b00, 1'b1, 8'hFF, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[9]  = '{2'b00, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h5A, 8'hFF, 1'b0};
        tbl[10] = '{2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        secret0 = 8'hA5; secret1 = 8'h55;
        m_pend = 0; m_sv = 0; m_turn = 0; m_gnt = 0; m_osrc = 0; m_to = 0;
        m_sec = 0; m_s0 = 0; m_s1 = 0; m_wait = 0;
        rst = 1'b1;
        set_in(2'b11, 1'b1, 8'h77, 1'b1);
        @(posedge clk); #1;
        cycle();
        chk("rst_req_ready", 32'(s_rq), 32'd0);
        chk("rst_rnd_ready", 32'(s_rr), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].rv, tbl[i].rvld, tbl[i].rnd, tbl[i].sr);
            cycle();
            chk($sformatf("tbl%0d_req_ready", i), 32'(s_rq), 32'(tbl[i].e_rq));
            chk($sformatf("tbl%0d_rnd_ready", i), 32'(s_rr), 32'(tbl[i].e_rr));
            chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_share_valid", i), 32'(s_sv), 32'(tbl[i].e_sv));
            chk($sformatf("tbl%0d_shares", i), {16'd0, s_sh0, s_sh1}, {16'd0, tbl[i].e_sh0, tbl[i].e_sh1});
            chk($sformatf("tbl%0d_share_src", i), 32'(s_src), 32'(tbl[i].e_src));
        end

        do_reset();
        set_in(2'b01, 1'b0, 8'h00, 1'b0);
        cycle();
        set_in(2'b00, 1'b0, 8'h00, 1'b0);
        rr_cnt = 0; to_cnt = 0; sv_cnt = 0; to_busy = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            rr_cnt += int'(s_rr); to_cnt += int'(s_to); sv_cnt += int'(s_sv);
            if (s_to) to_busy += int'(s_busy);
        end
        chk("timeout_wait_cycles", 32'(rr_cnt), 32'd16);
        chk("timeout_pulses", 32'(to_cnt), 32'd1);
        chk("timeout_no_shares", 32'(sv_cnt), 32'd0);
        chk("timeout_busy_low", 32'(to_busy), 32'd0);

        set_in(2'b01, 1'b0, 8'h00, 1'b0);
        cycle();
        set_in(2'b00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < TO - 1; i++) cycle();
        set_in(2'b00, 1'b1, 8'hC3, 1'b0);
        cycle();
        set_in(2'b11, 1'b0, 8'h00, 1'b0);
        to_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            to_cnt += int'(s_to);
            chk("stall_valid", 32'(s_sv), 32'd1);
            chk("stall_shares", {16'd0, s_sh0, s_sh1}, {16'd0, 8'hA5 ^ 8'hC3, 8'hC3});
            chk("stall_ready_outs", {29'd0, s_rq, s_rr}, 32'd0);
        end
        chk("late_rnd_no_timeout", 32'(to_cnt), 32'd0);
        set_in(2'b00, 1'b0, 8'h00, 1'b1);
        cycle();
        set_in(2'b00, 1'b0, 8'h00, 1'b0);
        cycle();
        chk("release_cleared", {15'd0, s_sv, s_sh0, s_sh1}, 32'd0);

        set_in(2'b01, 1'b0, 8'h00, 1'b0);
        cycle();
        rst = 1'b1;
        set_in(2'b00, 1'b1, 8'h5E, 1'b0);
        cycle();
        chk("rst_mid_rnd_ready", 32'(s_rr), 32'd0);
        rst = 1'b0;
        set_in(2'b00, 1'b0, 8'h00, 1'b0);
        cycle();
        chk("rst_mid_outputs", {13'd0, s_rq, s_rr, s_busy, s_sv, s_src, s_to, s_sh0, s_sh1}, 32'd0);

        secret0 = 8'h00;
        foreach (hist[i]) hist[i] = 0;
        for (int v = 0; v < 256; v++) begin
            set_in(2'b01, 1'b0, 8'h00, 1'b0);
            cycle();
            set_in(2'b00, 1'b1, 8'(v), 1'b0);
            cycle();
            set_in(2'b00, 1'b0, 8'h00, 1'b1);
            cycle();
            chk("zero_secret_share_eq", 32'(s_sh0), 32'(s_sh1));
            hist[s_sh0]++;
        end
        good = 0;
        foreach (hist[i]) good += int'(hist[i] == 1);
        chk("histogram_uniform_bins", 32'(good), 32'd256);

        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) mode = $urandom_range(0, 2);
            rst = ($urandom_range(0, 149) == 0);
            secret0 = 8'($urandom); secret1 = 8'($urandom);
            set_in(2'($urandom), (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0),
                   8'($urandom), 1'($urandom));
            cycle();
        end
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
